pc16: RTL and testbench

- 16-bit program counter; the registered stage directly downstream of the inc16 incrementer, which supplies its out+1 value.
- Adds a small hardware return-address stack so call/return sequences need no memory traffic.
- Its output feeds instruction-memory addressing, and loops back into the inc16 input.

---
 rtl/pc16_pkg.sv | 16 +
 rtl/inc16.sv | 12 +
 rtl/pc16_ret_stack.sv | 57 +++++
 rtl/pc16.sv | 100 ++++++++++
 tb/tb_pc16.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/pc16_pkg.sv
// pc16_pkg: shared PC/return-stack definitions.
// Command priority encoding and default address width.
package pc16_pkg;

  localparam int PC_WIDTH = 16;

  typedef logic [2:0] cmd_t;

  localparam cmd_t CMD_CLR  = 3'd0;
  localparam cmd_t CMD_RET  = 3'd1;
  localparam cmd_t CMD_CALL = 3'd2;
  localparam cmd_t CMD_LOAD = 3'd3;
  localparam cmd_t CMD_INC  = 3'd4;
  localparam cmd_t CMD_HOLD = 3'd5;

endpackage

// File: rtl/inc16.sv
// inc16: combinational +1 incrementer, wraps at all-ones.
// Ports: in (value), out (value + 1).
module inc16 #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out
);

  assign out = in + WIDTH'(1);

endmodule

// File: rtl/pc16_ret_stack.sv
// ret_stack: LIFO of return addresses with count/full/empty.
// Ports: clk, rst_n, clr, push, pop, push_data, top, count, full, empty.
module ret_stack
  import pc16_pkg::*;
#(
  parameter int WIDTH = PC_WIDTH,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           push_data,
  output logic [WIDTH-1:0]           top,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int IW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0]    top_cnt;
  logic [IW-1:0]    wr_idx;
  logic [IW-1:0]    rd_idx;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign top_cnt = count - CW'(1);
  assign wr_idx  = count[IW-1:0];
  assign rd_idx  = top_cnt[IW-1:0];

  // Gate the read so an empty stack never exposes stale entries.
  assign top = empty ? '0 : mem[rd_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (push && !full) begin
      count <= count + CW'(1);
    end else if (pop && !empty) begin
      count <= count - CW'(1);
    end
  end

  // Contents need no reset; only count-qualified reads are used.
  always_ff @(posedge clk) begin
    if (!clr && push && !full) begin
      mem[wr_idx] <= push_data;
    end
  end

endmodule

// File: rtl/pc16.sv
// pc16: program counter with hardware return-address stack.
// Ports: clk, rst_n, clr, load, inc, call, ret, in, out, sp_count, ovf, unf.
module pc16
  import pc16_pkg::*;
#(
  parameter int               WIDTH      = PC_WIDTH,
  parameter int               DEPTH      = 8,
  parameter logic [WIDTH-1:0] RESET_ADDR = '0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic                       load,
  input  logic                       inc,
  input  logic                       call,
  input  logic                       ret,
  input  logic [WIDTH-1:0]           in,
  output logic [WIDTH-1:0]           out,
  output logic [$clog2(DEPTH+1)-1:0] sp_count,
  output logic                       ovf,
  output logic                       unf
);

  cmd_t             cmd;
  logic [WIDTH-1:0] pc_inc;
  logic [WIDTH-1:0] top;
  logic [WIDTH-1:0] pc_nxt;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  always_comb begin
    cmd = CMD_HOLD;
    priority case (1'b1)
      clr:     cmd = CMD_CLR;
      ret:     cmd = CMD_RET;
      call:    cmd = CMD_CALL;
      load:    cmd = CMD_LOAD;
      inc:     cmd = CMD_INC;
      default: cmd = CMD_HOLD;
    endcase
  end

  assign push = (cmd == CMD_CALL) && !full;
  assign pop  = (cmd == CMD_RET) && !empty;

  inc16 #(
    .WIDTH (WIDTH)
  ) u_inc (
    .in  (out),
    .out (pc_inc)
  );

  ret_stack #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_stack (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (cmd == CMD_CLR),
    .push      (push),
    .pop       (pop),
    .push_data (pc_inc),
    .top       (top),
    .count     (sp_count),
    .full      (full),
    .empty     (empty)
  );

  always_comb begin
    pc_nxt = out;
    case (cmd)
      CMD_CLR:  pc_nxt = RESET_ADDR;
      CMD_RET:  pc_nxt = empty ? out : top;
      CMD_CALL: pc_nxt = full ? out : in;
      CMD_LOAD: pc_nxt = in;
      CMD_INC:  pc_nxt = pc_inc;
      default:  pc_nxt = out;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out <= RESET_ADDR;
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      out <= pc_nxt;
      if (cmd == CMD_CLR) begin
        ovf <= 1'b0;
        unf <= 1'b0;
      end else begin
        if (cmd == CMD_CALL && full) ovf <= 1'b1;
        if (cmd == CMD_RET && empty) unf <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pc16.sv
// tb_pc16: directed test of pc16 against a queue-based model.
// Checks every negedge plus hand-computed literal points.
module tb_pc16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr = 1'b0;
  logic        load = 1'b0;
  logic        inc = 1'b0;
  logic        call = 1'b0;
  logic        ret = 1'b0;
  logic [15:0] in = '0;
  logic [15:0] out;
  logic [3:0]  sp_count;
  logic        ovf;
  logic        unf;

  int n_chk = 0;
  int n_err = 0;

  logic [15:0] m_pc = 16'h0000;
  logic [15:0] m_stk[$];
  logic        m_ovf = 1'b0;
  logic        m_unf = 1'b0;

  pc16 dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .load     (load),
    .inc      (inc),
    .call     (call),
    .ret      (ret),
    .in       (in),
    .out      (out),
    .sp_count (sp_count),
    .ovf      (ovf),
    .unf      (unf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model: the spec's command rules over a queue stack.
  task automatic model_step();
    if (clr) begin
      m_pc = 16'h0000;
      m_stk.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else if (ret) begin
      if (m_stk.size() > 0) m_pc = m_stk.pop_back();
      else m_unf = 1'b1;
    end else if (call) begin
      if (m_stk.size() < 8) begin
        m_stk.push_back(m_pc + 16'd1);
        m_pc = in;
      end else begin
        m_ovf = 1'b1;
      end
    end else if (load) begin
      m_pc = in;
    end else if (inc) begin
      m_pc = m_pc + 16'd1;
    end
  endtask

  task automatic step(input logic c, input logic r, input logic ca,
                      input logic l, input logic i, input logic [15:0] d);
    clr = c; ret = r; call = ca; load = l; inc = i; in = d;
    @(posedge clk);
    model_step();
    #1;
    clr = 0; ret = 0; call = 0; load = 0; inc = 0;
  endtask

  // Literal check of both DUT and model against a hand value.
  task automatic lit(input string name, input logic [15:0] pc,
                     input int sp, input logic o, input logic u);
    chk({name, ".out"}, 32'(out), 32'(pc));
    chk({name, ".sp"}, 32'(sp_count), 32'(sp));
    chk({name, ".ovf"}, 32'(ovf), 32'(o));
    chk({name, ".unf"}, 32'(unf), 32'(u));
    chk({name, ".model"}, 32'(m_pc), 32'(pc));
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      chk("cyc.out", 32'(out), 32'(m_pc));
      chk("cyc.sp", 32'(sp_count), 32'(m_stk.size()));
      chk("cyc.ovf", 32'(ovf), 32'(m_ovf));
      chk("cyc.unf", 32'(unf), 32'(m_unf));
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    lit("reset", 16'h0000, 0, 0, 0);
    rst_n = 1'b1;

    step(0,0,0,0,1,0); lit("inc1", 16'h0001, 0, 0, 0);
    step(0,0,0,0,1,0); lit("inc2", 16'h0002, 0, 0, 0);
    step(0,0,0,0,1,0); lit("inc3", 16'h0003, 0, 0, 0);

    step(0,0,0,1,0,16'hFFFE); lit("ldfffe", 16'hFFFE, 0, 0, 0);
    step(0,0,0,0,1,0); lit("incffff", 16'hFFFF, 0, 0, 0);
    step(0,0,0,0,1,0); lit("wrap", 16'h0000, 0, 0, 0);

    step(0,0,0,1,0,16'h0010);
    step(0,0,1,0,0,16'h0200); lit("call1", 16'h0200, 1, 0, 0);
    step(0,0,1,0,0,16'h0300); lit("call2", 16'h0300, 2, 0, 0);
    step(0,1,0,0,0,0); lit("ret1", 16'h0201, 1, 0, 0);
    step(0,1,0,0,0,0); lit("ret2", 16'h0011, 0, 0, 0);

    for (int k = 0; k < 8; k++) step(0,0,1,0,0,16'h1000 + 16'(16*k));
    lit("fill", 16'h1070, 8, 0, 0);
    step(0,0,1,0,0,16'h0ABC); lit("ovf", 16'h1070, 8, 1, 0);
    step(0,1,0,0,0,0); lit("retovf", 16'h1061, 7, 1, 0);
    for (int k = 0; k < 7; k++) step(0,1,0,0,0,0);
    lit("drain", 16'h0012, 0, 1, 0);

    step(1,0,0,0,0,0); lit("clr1", 16'h0000, 0, 0, 0);
    step(0,0,0,1,0,16'h0040);
    step(0,1,0,0,0,0); lit("unf", 16'h0040, 0, 0, 1);
    step(0,0,1,0,0,16'h0050); lit("unfcall", 16'h0050, 1, 0, 1);
    step(1,0,0,0,0,0); lit("clr2", 16'h0000, 0, 0, 0);

    step(0,0,0,1,1,16'h1234); lit("ld+inc", 16'h1234, 0, 0, 0);
    step(0,0,1,0,0,16'h2000); lit("call3", 16'h2000, 1, 0, 0);
    step(0,1,1,0,0,16'h3000); lit("call+ret", 16'h1235, 0, 0, 0);
    step(0,0,0,1,0,16'h0055);
    step(1,1,1,1,1,16'h7777); lit("clrall", 16'h0000, 0, 0, 0);

    step(0,0,0,1,0,16'h0077);
    step(0,0,1,0,0,16'h0100);
    step(0,1,0,0,0,0);
    step(0,1,0,0,0,0);
    lit("preRst", 16'h0078, 0, 0, 1);
    #1;
    rst_n = 1'b0;
    #1;
    m_pc = 16'h0000;
    m_stk.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    lit("midrst", 16'h0000, 0, 0, 0);
    rst_n = 1'b1;
    step(0,0,0,0,1,0); lit("postrst", 16'h0001, 0, 0, 0);

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
